switch_logic_unit: RTL and testbench



---
 rtl/switch_logic_unit.sv | 107 ++++++++++
 tb/tb_switch_logic_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_logic_unit.sv
// Board switch-to-LED block: synchronises and debounces NUM_SW switches plus a
// mode button, reduces the switches with a selectable gate and registers the LEDs.
module switch_logic_unit #(
  parameter int NUM_SW          = 2,
  parameter int NUM_LED         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw,
  input  logic              btn,
  output logic [NUM_LED-1:0] led
);

  localparam int unsigned NUM_IN = NUM_SW + 1;
  localparam int          CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_NAND = 2'b11
  } mode_e;

  logic [NUM_IN-1:0]  raw;
  logic [NUM_IN-1:0]  sync1_q, sync1_d;
  logic [NUM_IN-1:0]  sync2_q, sync2_d;
  logic [NUM_IN-1:0]  stable_q, stable_d;
  logic [CNT_W-1:0]   cnt_q [NUM_IN];
  logic [CNT_W-1:0]   cnt_d [NUM_IN];
  logic               btn_prev_q, btn_prev_d;
  mode_e              mode_q, mode_d;
  logic [NUM_LED-1:0] led_q, led_d;

  logic [NUM_SW-1:0]  sw_stable;
  logic               btn_stable;
  logic               reduced;

  // Button rides as the top bit so all inputs share one debounce loop.
  assign raw = {btn, sw};

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // The LED uses the next mode so a mode change and a switch change accepted
  // on the same edge appear together on the following edge.
  always_comb begin
    sw_stable  = stable_q[NUM_SW-1:0];
    btn_stable = stable_q[NUM_IN-1];
    btn_prev_d = btn_stable;
    mode_d     = mode_q;
    if (btn_stable && !btn_prev_q) begin
      mode_d = mode_e'(mode_q + 2'd1);
    end
    case (mode_d)
      MODE_AND:  reduced = &sw_stable;
      MODE_OR:   reduced = |sw_stable;
      MODE_XOR:  reduced = ^sw_stable;
      MODE_NAND: reduced = ~&sw_stable;
      default:   reduced = 1'b0;
    endcase
    led_d      = '0;
    led_d[0]   = reduced;
    led_d[2:1] = mode_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        cnt_q[i] <= '0;
      end
      btn_prev_q <= 1'b0;
      mode_q     <= MODE_AND;
      led_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      btn_prev_q <= btn_prev_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_switch_logic_unit.sv
// Scoreboard bench for switch_logic_unit with NUM_SW=3, NUM_LED=4, DEBOUNCE_CYCLES=4.
module tb_switch_logic_unit;

  localparam int NSW  = 3;
  localparam int NLED = 4;
  localparam int DB   = 4;
  localparam int LAT  = DB + 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NSW-1:0]  sw;
  logic            btn;
  logic [NLED-1:0] led;

  int vectors     = 0;
  int miscompares = 0;

  logic [NLED-1:0] exp_q [$];
  logic [NLED-1:0] cur_exp;
  logic [NLED-1:0] exp_v;

  switch_logic_unit #(
    .NUM_SW(NSW),
    .NUM_LED(NLED),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .btn(btn),
    .led(led)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw    = 3'b111;
    btn   = 1'b1;
    tick(3);
    vectors++;
    if (led !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_hold: led=%b expected %b", led, 4'b0000);
    end
    cur_exp = 4'b0000;
    rst_n   = 1'b1;
    btn     = 1'b0;
    exp_q.push_back(4'b0001);
    for (int e = 1; e < LAT; e++) begin
      tick(1);
      vectors++;
      if (led !== cur_exp) begin
        miscompares++;
        $display("FAIL reset_early edge %0d: led=%b expected %b", e, led, cur_exp);
      end
    end
    tick(1);
    exp_v = exp_q.pop_front();
    vectors++;
    if (led !== exp_v) begin
      miscompares++;
      $display("FAIL reset_release_and: led=%b expected %b", led, exp_v);
    end
    cur_exp = exp_v;
  endtask

  task automatic test_mode_cycling();
    logic [NLED-1:0] steps [4];
    steps[0] = 4'b0011;
    steps[1] = 4'b0100;
    steps[2] = 4'b0111;
    steps[3] = 4'b0000;
    sw = 3'b101;
    exp_q.push_back(4'b0000);
    tick(LAT);
    exp_v = exp_q.pop_front();
    vectors++;
    if (led !== exp_v) begin
      miscompares++;
      $display("FAIL mode_setup: led=%b expected %b", led, exp_v);
    end
    cur_exp = exp_v;
    for (int p = 0; p < 4; p++) begin
      btn = 1'b1;
      exp_q.push_back(steps[p]);
      tick(LAT - 1);
      vectors++;
      if (led !== cur_exp) begin
        miscompares++;
        $display("FAIL mode_early press %0d: led=%b expected %b", p, led, cur_exp);
      end
      tick(1);
      exp_v = exp_q.pop_front();
      vectors++;
      if (led !== exp_v) begin
        miscompares++;
        $display("FAIL mode_step press %0d: led=%b expected %b", p, led, exp_v);
      end
      cur_exp = exp_v;
      tick(3);
      btn = 1'b0;
      tick(10);
      vectors++;
      if (led !== cur_exp) begin
        miscompares++;
        $display("FAIL mode_release press %0d: led=%b expected %b", p, led, cur_exp);
      end
    end
  endtask

  task automatic test_bounce();
    sw = 3'b110;
    tick(LAT + 2);
    vectors++;
    if (led !== 4'b0000) begin
      miscompares++;
      $display("FAIL bounce_setup: led=%b expected %b", led, 4'b0000);
    end
    cur_exp = 4'b0000;
    for (int p = 0; p < 5; p++) begin
      sw = 3'b111;
      for (int c = 0; c < 3; c++) begin
        tick(1);
        vectors++;
        if (led !== cur_exp) begin
          miscompares++;
          $display("FAIL bounce_hi pulse %0d: led=%b expected %b", p, led, cur_exp);
        end
      end
      sw = 3'b110;
      for (int c = 0; c < 3; c++) begin
        tick(1);
        vectors++;
        if (led !== cur_exp) begin
          miscompares++;
          $display("FAIL bounce_lo pulse %0d: led=%b expected %b", p, led, cur_exp);
        end
      end
    end
    sw = 3'b111;
    exp_q.push_back(4'b0001);
    for (int e = 1; e < LAT; e++) begin
      tick(1);
      vectors++;
      if (led !== cur_exp) begin
        miscompares++;
        $display("FAIL bounce_settle_early edge %0d: led=%b expected %b", e, led, cur_exp);
      end
    end
    tick(1);
    exp_v = exp_q.pop_front();
    vectors++;
    if (led !== exp_v) begin
      miscompares++;
      $display("FAIL bounce_settle: led=%b expected %b", led, exp_v);
    end
    cur_exp = exp_v;
  endtask

  task automatic test_held_button();
    btn = 1'b1;
    exp_q.push_back(4'b0011);
    tick(LAT - 1);
    vectors++;
    if (led !== cur_exp) begin
      miscompares++;
      $display("FAIL held_early: led=%b expected %b", led, cur_exp);
    end
    tick(1);
    exp_v = exp_q.pop_front();
    vectors++;
    if (led !== exp_v) begin
      miscompares++;
      $display("FAIL held_advance: led=%b expected %b", led, exp_v);
    end
    cur_exp = exp_v;
    tick(50 - LAT);
    vectors++;
    if (led !== cur_exp) begin
      miscompares++;
      $display("FAIL held_once: led=%b expected %b", led, cur_exp);
    end
    btn = 1'b0;
    tick(20);
    vectors++;
    if (led !== cur_exp) begin
      miscompares++;
      $display("FAIL held_release: led=%b expected %b", led, cur_exp);
    end
  endtask

  task automatic test_reset_mid_debounce();
    sw = 3'b000;
    exp_q.push_back(4'b0010);
    tick(LAT + 2);
    exp_v = exp_q.pop_front();
    vectors++;
    if (led !== exp_v) begin
      miscompares++;
      $display("FAIL midrst_setup: led=%b expected %b", led, exp_v);
    end
    sw = 3'b111;
    tick(4);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (led !== 4'b0000) begin
      miscompares++;
      $display("FAIL midrst_async_clear: led=%b expected %b", led, 4'b0000);
    end
    cur_exp = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    exp_q.push_back(4'b0001);
    for (int e = 1; e < LAT; e++) begin
      tick(1);
      vectors++;
      if (led !== cur_exp) begin
        miscompares++;
        $display("FAIL midrst_early edge %0d: led=%b expected %b", e, led, cur_exp);
      end
    end
    tick(1);
    exp_v = exp_q.pop_front();
    vectors++;
    if (led !== exp_v) begin
      miscompares++;
      $display("FAIL midrst_recount: led=%b expected %b", led, exp_v);
    end
    cur_exp = exp_v;
  endtask

  task automatic test_simultaneous();
    sw = 3'b110;
    exp_q.push_back(4'b0000);
    tick(LAT + 2);
    exp_v = exp_q.pop_front();
    vectors++;
    if (led !== exp_v) begin
      miscompares++;
      $display("FAIL simul_setup: led=%b expected %b", led, exp_v);
    end
    cur_exp = exp_v;
    sw  = 3'b111;
    btn = 1'b1;
    exp_q.push_back(4'b0011);
    for (int e = 1; e < LAT; e++) begin
      tick(1);
      vectors++;
      if (led !== cur_exp) begin
        miscompares++;
        $display("FAIL simul_intermediate edge %0d: led=%b expected %b", e, led, cur_exp);
      end
    end
    tick(1);
    exp_v = exp_q.pop_front();
    vectors++;
    if (led !== exp_v) begin
      miscompares++;
      $display("FAIL simul_both: led=%b expected %b", led, exp_v);
    end
    cur_exp = exp_v;
    tick(5);
    btn = 1'b0;
    tick(10);
    vectors++;
    if (led !== cur_exp) begin
      miscompares++;
      $display("FAIL simul_release: led=%b expected %b", led, cur_exp);
    end
  endtask

  initial begin
    test_reset();
    test_mode_cycling();
    test_bounce();
    test_held_button();
    test_reset_mid_debounce();
    test_simultaneous();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: pending=%0d expected %0d", exp_q.size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
